// File: rtl/memory_port_arbiter.sv
// Two-master arbiter (instruction fetch, data load/store) onto one backing-memory port
// with a wait-cycle timeout. Define ARB_INSTR_FAIRNESS_EN to alternate grants under contention.
module memory_port_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  instrReq,
  input  logic [DATA_WIDTH-1:0] instrAddr,
  output logic [DATA_WIDTH-1:0] instrRdata,
  output logic                  instrDone,
  output logic                  instrErr,
  input  logic                  dataReq,
  input  logic                  dataWrite,
  input  logic [DATA_WIDTH-1:0] dataAddr,
  input  logic [DATA_WIDTH-1:0] dataWdata,
  output logic [DATA_WIDTH-1:0] dataRdata,
  output logic                  dataDone,
  output logic                  dataErr,
  output logic                  memReq,
  output logic                  memWe,
  output logic [DATA_WIDTH-1:0] memAddr,
  output logic [DATA_WIDTH-1:0] memWdata,
  input  logic [DATA_WIDTH-1:0] memRdata,
  input  logic                  memAck
);

  typedef enum logic [1:0] {IDLE, INSTR_BUSY, DATA_BUSY} state_t;

  // Timeout fires in the cycle the counter would reach TIMEOUT_CYCLES.
  localparam logic [7:0] TO_LAST = (TIMEOUT_CYCLES == 0) ? 8'd0 : 8'(TIMEOUT_CYCLES - 1);

  state_t                r_state, w_next;
  logic [DATA_WIDTH-1:0] r_addr, r_wdata, r_instrRdata, r_dataRdata;
  logic                  r_we;
  logic [7:0]            r_wait;
  logic                  w_busy, w_timeout, w_finish, w_grant_data, w_grant_instr;

`ifdef ARB_INSTR_FAIRNESS_EN
  logic r_fair;
  assign w_grant_data = dataReq && !(instrReq && r_fair);
`else
  assign w_grant_data = dataReq;
`endif
  assign w_grant_instr = instrReq && !w_grant_data;

  assign w_busy    = (r_state != IDLE);
  assign w_timeout = w_busy && !memAck && (TIMEOUT_CYCLES != 0) && (r_wait == TO_LAST);
  assign w_finish  = w_busy && (memAck || w_timeout);

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_grant_data)       w_next = DATA_BUSY;
        else if (w_grant_instr) w_next = INSTR_BUSY;
      end
      INSTR_BUSY, DATA_BUSY: if (w_finish) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Completion is combinational with memAck; reset suppresses any pulse in its own cycle.
  always_comb begin
    instrDone  = 1'b0;
    instrErr   = 1'b0;
    dataDone   = 1'b0;
    dataErr    = 1'b0;
    instrRdata = r_instrRdata;
    dataRdata  = r_dataRdata;
    if (!reset) begin
      if (r_state == INSTR_BUSY) begin
        instrDone = w_finish;
        instrErr  = w_timeout;
        if (memAck) instrRdata = memRdata;
      end
      if (r_state == DATA_BUSY) begin
        dataDone = w_finish;
        dataErr  = w_timeout;
        if (memAck && !r_we) dataRdata = memRdata;
      end
    end
  end

  assign memReq   = w_busy;
  assign memWe    = w_busy && r_we;
  assign memAddr  = r_addr;
  assign memWdata = r_wdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_we         <= 1'b0;
      r_wait       <= 8'd0;
      r_instrRdata <= '0;
      r_dataRdata  <= '0;
`ifdef ARB_INSTR_FAIRNESS_EN
      r_fair       <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      if (r_state == IDLE) begin
        if (w_grant_data) begin
          r_addr  <= dataAddr;
          r_wdata <= dataWdata;
          r_we    <= dataWrite;
          r_wait  <= 8'd0;
`ifdef ARB_INSTR_FAIRNESS_EN
          r_fair  <= 1'b1;
`endif
        end else if (w_grant_instr) begin
          r_addr  <= instrAddr;
          r_wdata <= '0;
          r_we    <= 1'b0;
          r_wait  <= 8'd0;
`ifdef ARB_INSTR_FAIRNESS_EN
          r_fair  <= 1'b0;
`endif
        end
      end else if (!memAck) begin
        r_wait <= r_wait + 8'd1;
      end
      if (r_state == INSTR_BUSY && memAck)         r_instrRdata <= memRdata;
      if (r_state == DATA_BUSY && memAck && !r_we) r_dataRdata  <= memRdata;
    end
  end

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Directed bench for memory_port_arbiter: fetch, priority, load, timeout, reset, contention.
module tb_memory_port_arbiter;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset, instrReq, dataReq, dataWrite, memAck;
  logic [DW-1:0] instrAddr, dataAddr, dataWdata, memRdata;
  logic [DW-1:0] instrRdata, dataRdata, memAddr, memWdata;
  logic          instrDone, instrErr, dataDone, dataErr, memReq, memWe;
  int            n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  memory_port_arbiter #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .instrReq(instrReq), .instrAddr(instrAddr), .instrRdata(instrRdata),
    .instrDone(instrDone), .instrErr(instrErr),
    .dataReq(dataReq), .dataWrite(dataWrite), .dataAddr(dataAddr), .dataWdata(dataWdata),
    .dataRdata(dataRdata), .dataDone(dataDone), .dataErr(dataErr),
    .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWdata(memWdata),
    .memRdata(memRdata), .memAck(memAck)
  );

  task step;
    @(posedge clk);
    #1;
  endtask

  task test_reset;
    reset = 1; memAck = 1; memRdata = 32'hFFFF_FFFF;
    step; step;
    @(negedge clk);
    n_chk++; if (memReq !== 1'b0)    begin n_fail++; $display("FAIL rst_memReq got %b exp 0", memReq); end
    n_chk++; if (memWe !== 1'b0)     begin n_fail++; $display("FAIL rst_memWe got %b exp 0", memWe); end
    n_chk++; if ({instrDone, instrErr, dataDone, dataErr} !== 4'b0)
      begin n_fail++; $display("FAIL rst_done got %b exp 0000", {instrDone, instrErr, dataDone, dataErr}); end
    n_chk++; if (instrRdata !== '0)  begin n_fail++; $display("FAIL rst_instrRdata got %h exp 0", instrRdata); end
    n_chk++; if (dataRdata !== '0)   begin n_fail++; $display("FAIL rst_dataRdata got %h exp 0", dataRdata); end
    step;
    reset = 0;
    @(negedge clk);
    n_chk++; if (memReq !== 1'b0 || instrDone !== 1'b0)
      begin n_fail++; $display("FAIL idle_ack_ignored memReq %b instrDone %b exp 0 0", memReq, instrDone); end
    step;
    memAck = 0; memRdata = 0;
  endtask

  task test_instr_fetch;
    instrReq = 1; instrAddr = 32'h10;
    @(negedge clk);
    n_chk++; if (memReq !== 1'b0) begin n_fail++; $display("FAIL fetch_c0_memReq got %b exp 0", memReq); end
    step;
    memAck = 1; memRdata = 32'h0050_0093;
    @(negedge clk);
    n_chk++; if (memReq !== 1'b1 || memWe !== 1'b0)
      begin n_fail++; $display("FAIL fetch_memReq got %b/%b exp 1/0", memReq, memWe); end
    n_chk++; if (memAddr !== 32'h10) begin n_fail++; $display("FAIL fetch_memAddr got %h exp 10", memAddr); end
    n_chk++; if (instrDone !== 1'b1 || instrErr !== 1'b0 || dataDone !== 1'b0)
      begin n_fail++; $display("FAIL fetch_done got %b%b%b exp 100", instrDone, instrErr, dataDone); end
    n_chk++; if (instrRdata !== 32'h0050_0093)
      begin n_fail++; $display("FAIL fetch_rdata got %h exp 00500093", instrRdata); end
    step;
    instrReq = 0; memAck = 0; memRdata = 0;
    @(negedge clk);
    n_chk++; if (memReq !== 1'b0 || instrDone !== 1'b0)
      begin n_fail++; $display("FAIL fetch_after got memReq %b done %b exp 0 0", memReq, instrDone); end
    n_chk++; if (instrRdata !== 32'h0050_0093)
      begin n_fail++; $display("FAIL fetch_rdata_hold got %h exp 00500093", instrRdata); end
  endtask

  task test_priority;
    step;
    dataReq = 1; dataWrite = 1; dataAddr = 32'h40; dataWdata = 32'hDEAD_BEEF;
    instrReq = 1; instrAddr = 32'h80;
    step;
    memAck = 1; memRdata = 32'h5555_5555;
    @(negedge clk);
    n_chk++; if (memReq !== 1'b1 || memWe !== 1'b1)
      begin n_fail++; $display("FAIL prio_store_we got %b/%b exp 1/1", memReq, memWe); end
    n_chk++; if (memAddr !== 32'h40 || memWdata !== 32'hDEAD_BEEF)
      begin n_fail++; $display("FAIL prio_store_bus got %h/%h exp 40/deadbeef", memAddr, memWdata); end
    n_chk++; if (dataDone !== 1'b1 || dataErr !== 1'b0 || instrDone !== 1'b0)
      begin n_fail++; $display("FAIL prio_store_done got %b%b%b exp 100", dataDone, dataErr, instrDone); end
    n_chk++; if (dataRdata !== '0) begin n_fail++; $display("FAIL store_no_rdata got %h exp 0", dataRdata); end
    step;
    dataReq = 0; dataWrite = 0; memAck = 0;
    @(negedge clk);
    n_chk++; if (memReq !== 1'b0 || dataDone !== 1'b0)
      begin n_fail++; $display("FAIL prio_gap got memReq %b done %b exp 0 0", memReq, dataDone); end
    step;
    memAck = 1; memRdata = 32'h1234;
    @(negedge clk);
    n_chk++; if (memReq !== 1'b1 || memWe !== 1'b0 || memAddr !== 32'h80)
      begin n_fail++; $display("FAIL prio_instr_bus got %b/%b/%h exp 1/0/80", memReq, memWe, memAddr); end
    n_chk++; if (instrDone !== 1'b1 || dataDone !== 1'b0)
      begin n_fail++; $display("FAIL prio_instr_done got %b/%b exp 1/0", instrDone, dataDone); end
    step;
    instrReq = 0; memAck = 0;
    @(negedge clk);
  endtask

  task test_load;
    step;
    dataReq = 1; dataWrite = 0; dataAddr = 32'h44;
    step;
    memAck = 1; memRdata = 32'hCAFE_0001;
    @(negedge clk);
    n_chk++; if (dataDone !== 1'b1 || dataRdata !== 32'hCAFE_0001)
      begin n_fail++; $display("FAIL load got done %b rdata %h exp 1 cafe0001", dataDone, dataRdata); end
    step;
    dataReq = 0; memAck = 0; memRdata = 0;
    @(negedge clk);
    n_chk++; if (dataRdata !== 32'hCAFE_0001 || memReq !== 1'b0)
      begin n_fail++; $display("FAIL load_hold got %h/%b exp cafe0001/0", dataRdata, memReq); end
  endtask

  task test_timeout;
    step;
    instrReq = 1; instrAddr = 32'h20;
    step;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c < 4) begin
        n_chk++; if (instrDone !== 1'b0 || memReq !== 1'b1)
          begin n_fail++; $display("FAIL to_wait%0d got done %b memReq %b exp 0 1", c, instrDone, memReq); end
        step;
      end else begin
        n_chk++; if (instrDone !== 1'b1 || instrErr !== 1'b1)
          begin n_fail++; $display("FAIL to_fire got %b/%b exp 1/1", instrDone, instrErr); end
        n_chk++; if (instrRdata !== 32'h1234 || dataErr !== 1'b0)
          begin n_fail++; $display("FAIL to_rdata got %h/%b exp 1234/0", instrRdata, dataErr); end
      end
    end
    step;
    instrReq = 0;
    @(negedge clk);
    n_chk++; if (memReq !== 1'b0 || instrErr !== 1'b0)
      begin n_fail++; $display("FAIL to_idle got %b/%b exp 0/0", memReq, instrErr); end
    step;
    instrReq = 1;
    step; step; step; step;
    memAck = 1; memRdata = 32'hABCD;
    @(negedge clk);
    n_chk++; if (instrDone !== 1'b1 || instrErr !== 1'b0 || instrRdata !== 32'hABCD)
      begin n_fail++; $display("FAIL to_ack_wins got %b/%b/%h exp 1/0/abcd", instrDone, instrErr, instrRdata); end
    step;
    instrReq = 0; memAck = 0;
    @(negedge clk);
  endtask

  task test_reset_mid;
    step;
    dataReq = 1; dataWrite = 0; dataAddr = 32'h48;
    step;
    @(negedge clk);
    n_chk++; if (memReq !== 1'b1) begin n_fail++; $display("FAIL rmid_busy got %b exp 1", memReq); end
    step;
    reset = 1; memAck = 1; memRdata = 32'h77;
    @(negedge clk);
    n_chk++; if (dataDone !== 1'b0) begin n_fail++; $display("FAIL rmid_nodone got %b exp 0", dataDone); end
    step;
    reset = 0; memAck = 0; dataReq = 0;
    @(negedge clk);
    n_chk++; if (memReq !== 1'b0 || dataDone !== 1'b0)
      begin n_fail++; $display("FAIL rmid_after got %b/%b exp 0/0", memReq, dataDone); end
    n_chk++; if (dataRdata !== '0) begin n_fail++; $display("FAIL rmid_rdata got %h exp 0", dataRdata); end
  endtask

  task test_back_to_back;
    int nd, ni, exp_d, exp_i;
    nd = 0; ni = 0;
`ifdef ARB_INSTR_FAIRNESS_EN
    exp_d = 2; exp_i = 1;
`else
    exp_d = 3; exp_i = 0;
`endif
    step;
    reset = 1;
    step;
    reset = 0; dataReq = 1; dataWrite = 0; dataAddr = 32'h50; instrReq = 1; instrAddr = 32'h60;
    memAck = 1; memRdata = 32'h99;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      nd += int'(dataDone);
      ni += int'(instrDone);
      step;
    end
    dataReq = 0; instrReq = 0; memAck = 0;
    n_chk++; if (nd !== exp_d) begin n_fail++; $display("FAIL b2b_data_dones got %0d exp %0d", nd, exp_d); end
    n_chk++; if (ni !== exp_i) begin n_fail++; $display("FAIL b2b_instr_dones got %0d exp %0d", ni, exp_i); end
    @(negedge clk);
  endtask

  initial begin
    reset = 1; instrReq = 0; dataReq = 0; dataWrite = 0; memAck = 0;
    instrAddr = 0; dataAddr = 0; dataWdata = 0; memRdata = 0;
    test_reset;
    test_instr_fetch;
    test_priority;
    test_load;
    test_timeout;
    test_reset_mid;
    test_back_to_back;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/memory_port_arbiter.md
MEMORY_PORT_ARBITER -- requirements
Module: memory_port_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of every address and data bus.
REQ-002 Parameter TIMEOUT_CYCLES, default 255, the maximum number of BUSY cycles without memAck (0 = no timeout); the value SHALL fit in 8 bits.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 instrReq  input  1  instruction fetch request, held until instrDone.
REQ-006 instrAddr  input  DATA_WIDTH  fetch address (the PC).
REQ-007 instrRdata  output  DATA_WIDTH  fetched instruction.
REQ-008 instrDone  output  1  fetch complete, one-cycle pulse (drives instructionMemorySuccess).
REQ-009 instrErr  output  1  fetch timed out, asserted together with instrDone.
REQ-010 dataReq  input  1  MEM-stage request (memRead|memWrite), held until dataDone.
REQ-011 dataWrite  input  1  1 = store, 0 = load.
REQ-012 dataAddr, dataWdata  input  DATA_WIDTH each  address and store data.
REQ-013 dataRdata  output  DATA_WIDTH  load result.
REQ-014 dataDone, dataErr  output  1 each  completion pulse and timeout flag.
REQ-015 memReq, memWe  output  1 each  backing-memory request and write enable.
REQ-016 memAddr, memWdata  output  DATA_WIDTH each  backing-memory address and write data.
REQ-017 memRdata  input  DATA_WIDTH  backing-memory read data, valid while memAck=1.
REQ-018 memAck  input  1  backing memory completes the current access this cycle.

Function
REQ-019 FSM states SHALL be IDLE, INSTR_BUSY and DATA_BUSY.
REQ-020 In IDLE with a request: grant at the clock edge; latch address, write data and write enable (instruction: memWe=0); enter the owner's BUSY state.
REQ-021 Simultaneous requests in IDLE SHALL grant data (default priority).
REQ-022 memReq=1 exactly while in a BUSY state; memAddr/memWdata/memWe SHALL be stable throughout BUSY.
REQ-023 memAck in BUSY: the owner's done pulses in that same cycle (combinational), the owner's rdata equals memRdata that cycle, and the FSM returns to IDLE at the next edge.
REQ-024 Minimum latency: request seen in IDLE at cycle 0, memReq at cycle 1, done at cycle 1 if memAck is high at cycle 1.
REQ-025 instrRdata and dataRdata SHALL hold the last acknowledged value, registered, until the next ack for that owner; stores SHALL not update dataRdata.
REQ-026 The non-owner's done and err SHALL stay 0; memAck in IDLE SHALL be ignored.
REQ-027 An 8-bit wait counter SHALL clear on grant and increment each BUSY cycle without ack.
REQ-028 If TIMEOUT_CYCLES≠0 and the counter reaches TIMEOUT_CYCLES: owner done=1 and err=1 for one cycle, rdata unchanged, and IDLE at the next edge.
REQ-029 memAck in the timeout cycle SHALL take precedence: normal completion, err=0.
REQ-030 A request deasserted during BUSY SHALL not abort the access; the transaction completes and done still pulses.
REQ-031 The block SHALL be back-to-back capable: IDLE for exactly one cycle between transactions.

Reset
REQ-032 reset=1 at an edge: state IDLE; all registers 0; memReq, memWe, done and err 0 from that edge, including mid-transaction; an ack arriving in the reset cycle SHALL be discarded.

Configuration
REQ-033 Macro ARB_INSTR_FAIRNESS_EN. Defined: a data grant sets a fairness flag, and with the flag set simultaneous requests grant instruction, which clears the flag; the flag resets to 0. Undefined: strict data priority per REQ-021, no flag register.

Verification
REQ-034 instrReq=1, instrAddr=0x10, memAck at the first BUSY cycle with memRdata=0x00500093 -> memReq for 1 cycle, instrDone=1 that cycle, instrRdata=0x00500093.
REQ-035 dataReq=1, dataWrite=1, dataAddr=0x40, dataWdata=0xDEADBEEF, and instrReq=1 in the same cycle -> data granted first with memWe=1 and memAddr=0x40; instruction granted after one IDLE cycle.
REQ-036 Continuous simultaneous requests with single-cycle acks -> undefined macro: instrDone never pulses; defined: grants alternate data, instruction, data, ...
REQ-037 instrReq with no memAck and TIMEOUT_CYCLES=4 -> instrDone=1 and instrErr=1 at BUSY cycle 4, then IDLE; memAck at cycle 4 instead -> err=0.
REQ-038 reset=1 in the second BUSY cycle of a load -> memReq=0 next cycle, dataDone never pulses, dataRdata=0.
